// File: rtl/bram_rd_arbiter_pkg.sv
// Shared types and limits for the two-requester BRAM read arbiter.
// Latency: n/a (types only); backpressure: n/a.
package bram_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int NUM_REQ        = 2;
    localparam int RD_LATENCY_MAX = 4;

endpackage

// File: rtl/bram_rd_lat_pipe.sv
// Shift pipeline carrying valid/id/last tags alongside BRAM read data.
// Latency: DEPTH cycles; no backpressure, a tag advances every cycle.
module bram_rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    input  logic in_id,
    input  logic in_last,
    output logic out_vld,
    output logic out_id,
    output logic out_last
);

    logic [DEPTH-1:0] vld_sr;
    logic [DEPTH-1:0] id_sr;
    logic [DEPTH-1:0] last_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr  <= '0;
            id_sr   <= '0;
            last_sr <= '0;
        end else begin
            vld_sr[0]  <= in_vld;
            id_sr[0]   <= in_id;
            last_sr[0] <= in_last;
            for (int i = 1; i < DEPTH; i++) begin
                vld_sr[i]  <= vld_sr[i-1];
                id_sr[i]   <= id_sr[i-1];
                last_sr[i] <= last_sr[i-1];
            end
        end
    end

    assign out_vld  = vld_sr[DEPTH-1];
    assign out_id   = id_sr[DEPTH-1];
    assign out_last = last_sr[DEPTH-1];

endmodule

// File: rtl/bram_rd_arbiter.sv
// Arbitrates two burst readers onto one read-only BRAM port; data returns RD_LATENCY+1 cycles after
// each beat address, bursts never stall. Round-robin when BRAM_RD_ARB_RR_EN is defined, else fixed priority.
module bram_rd_arbiter
    import bram_rd_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_STEP  = 4,
    parameter int LEN_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               ram_clk,
    output logic               ram_rst,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [31:0]        ram_wd_data,
    output logic [31:0]        ram_addr,
    input  logic [31:0]        ram_rd_data,
    input  logic [NUM_REQ-1:0] req,
    input  logic [31:0]        req_addr0,
    input  logic [31:0]        req_addr1,
    input  logic [LEN_W-1:0]   req_len0,
    input  logic [LEN_W-1:0]   req_len1,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic               rd_id,
    output logic               rd_last,
    output logic [NUM_REQ-1:0] done
);

    localparam int PIPE_DEPTH = (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX :
                                (RD_LATENCY < 1) ? 1 : RD_LATENCY;
    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    arb_state_t       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt;
    logic             cur_id;
    logic             win_id;
    logic [31:0]      win_addr;
    logic [LEN_W-1:0] win_len;
    logic             issue_last;
    logic             p_vld;
    logic             p_id;
    logic             p_last;

    assign ram_clk     = clk;
    assign ram_rst     = 1'b0;
    assign ram_we      = 4'h0;
    assign ram_wd_data = 32'h0;

`ifdef BRAM_RD_ARB_RR_EN
    logic rr_ptr;

    // rr_ptr names the requester that wins a tie; it flips to the loser at every grant.
    always_comb win_id = (req == 2'b11) ? rr_ptr : ~req[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE && |req) begin
            rr_ptr <= ~win_id;
        end
    end
`else
    always_comb win_id = ~req[0];
`endif

    assign win_addr   = win_id ? req_addr1 : req_addr0;
    assign win_len    = win_id ? req_len1  : req_len0;
    assign issue_last = (state == ISSUE) && (beat_cnt == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            len_q    <= '0;
            beat_cnt <= '0;
            cur_id   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= ISSUE;
                        gnt      <= win_id ? 2'b10 : 2'b01;
                        cur_id   <= win_id;
                        ram_en   <= 1'b1;
                        ram_addr <= win_addr;
                        len_q    <= win_len;
                        beat_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (beat_cnt == len_q) begin
                        state    <= DRAIN;
                        ram_en   <= 1'b0;
                        ram_addr <= '0;
                    end else begin
                        ram_addr <= ram_addr + STEP;
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // Grant is held through the rd_last beat and dropped as we return to IDLE.
                    if (rd_valid && rd_last) begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    bram_rd_lat_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_lat_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (ram_en),
        .in_id   (cur_id),
        .in_last (issue_last),
        .out_vld (p_vld),
        .out_id  (p_id),
        .out_last(p_last)
    );

    // Pipe output lines up with ram_rd_data; this stage registers both together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_id    <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
            done     <= '0;
        end else begin
            rd_valid <= p_vld;
            rd_id    <= p_id;
            rd_last  <= p_vld & p_last;
            done     <= (p_vld && p_last) ? (p_id ? 2'b10 : 2'b01) : 2'b00;
            if (p_vld) begin
                rd_data <= ram_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_bram_rd_arbiter.sv
// Directed bench for bram_rd_arbiter: two instances (RD_LATENCY 1 and 3) checked against a beat scoreboard.
module tb_bram_rd_arbiter;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct packed {
        logic        u;
        logic [31:0] addr;
        logic        id;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req_s [2];
    logic [31:0] ra0 [2];
    logic [31:0] ra1 [2];
    logic [7:0]  rl0 [2];
    logic [7:0]  rl1 [2];

    logic        a_ram_clk, a_ram_rst, a_ram_en, a_rd_valid, a_rd_id, a_rd_last;
    logic [3:0]  a_ram_we;
    logic [31:0] a_ram_wd, a_ram_addr, a_ram_rd, a_rd_data;
    logic [1:0]  a_gnt, a_done;
    logic        b_ram_clk, b_ram_rst, b_ram_en, b_rd_valid, b_rd_id, b_rd_last;
    logic [3:0]  b_ram_we;
    logic [31:0] b_ram_wd, b_ram_addr, b_ram_rd, b_rd_data;
    logic [1:0]  b_gnt, b_done;
    logic [31:0] b_dly0, b_dly1;

    exp_t iss_q[$];
    exp_t sb_q[$];
    int   tq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cnt [2][2];
    logic [1:0] keep [2];
    logic prev_last [2];

    bram_rd_arbiter #(.RD_LATENCY(LAT0), .ADDR_STEP(4), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .ram_clk(a_ram_clk), .ram_rst(a_ram_rst), .ram_en(a_ram_en),
        .ram_we(a_ram_we), .ram_wd_data(a_ram_wd), .ram_addr(a_ram_addr), .ram_rd_data(a_ram_rd),
        .req(req_s[0]), .req_addr0(ra0[0]), .req_addr1(ra1[0]), .req_len0(rl0[0]), .req_len1(rl1[0]),
        .gnt(a_gnt), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_id(a_rd_id), .rd_last(a_rd_last),
        .done(a_done));

    bram_rd_arbiter #(.RD_LATENCY(LAT1), .ADDR_STEP(4), .LEN_W(8)) dut_lat3 (
        .clk(clk), .rst_n(rst_n), .ram_clk(b_ram_clk), .ram_rst(b_ram_rst), .ram_en(b_ram_en),
        .ram_we(b_ram_we), .ram_wd_data(b_ram_wd), .ram_addr(b_ram_addr), .ram_rd_data(b_ram_rd),
        .req(req_s[1]), .req_addr0(ra0[1]), .req_addr1(ra1[1]), .req_len0(rl0[1]), .req_len1(rl1[1]),
        .gnt(b_gnt), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_id(b_rd_id), .rd_last(b_rd_last),
        .done(b_done));

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // BRAM models: content is a fixed function of the address, delayed by each instance's latency.
    always @(posedge clk) a_ram_rd <= mem_f(a_ram_addr);
    always @(posedge clk) begin
        b_dly0   <= mem_f(b_ram_addr);
        b_dly1   <= b_dly0;
        b_ram_rd <= b_dly1;
    end

    task automatic chk(input string tag, input int u, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (unit %0d): observed %h, expected %h", tag, u, obs, exp);
        end
    endtask

    task automatic mon_one(input int u, input logic en, input logic [31:0] addr, input logic [1:0] g,
                           input logic vld, input logic [31:0] dat, input logic id, input logic last,
                           input logic [1:0] dn);
        exp_t e;
        int   t;
        logic [1:0] oh;
        int   lat = (u == 0) ? LAT0 : LAT1;
        if (en) begin
            chk("issue_expected", u, 32'(iss_q.size() != 0), 32'd1);
            if (iss_q.size() != 0) begin
                e  = iss_q.pop_front();
                oh = 2'b01 << e.id;
                chk("issue_unit", u, 32'(u), 32'(e.u));
                chk("ram_addr", u, addr, e.addr);
                chk("gnt_issue", u, 32'(g), 32'(oh));
                tq.push_back(cyc);
            end
        end else begin
            chk("ram_addr_idle", u, addr, 32'd0);
        end
        if (vld) begin
            chk("rd_expected", u, 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e  = sb_q.pop_front();
                t  = (tq.size() != 0) ? tq.pop_front() : -100;
                oh = 2'b01 << e.id;
                chk("rd_data", u, dat, mem_f(e.addr));
                chk("rd_id", u, 32'(id), 32'(e.id));
                chk("rd_last", u, 32'(last), 32'(e.last));
                chk("rd_latency", u, 32'(cyc - t), 32'(lat + 1));
                chk("gnt_drain", u, 32'(g), 32'(oh));
                chk("done", u, 32'(dn), e.last ? 32'(oh) : 32'd0);
                if (e.last) begin
                    done_cnt[u][e.id]++;
                    if (!keep[u][e.id]) req_s[u][e.id] = 1'b0;
                end
            end
        end else begin
            chk("done_idle", u, 32'(dn), 32'd0);
        end
        if (prev_last[u]) chk("gnt_clear", u, 32'(g), 32'd0);
        prev_last[u] = vld & last;
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        mon_one(0, a_ram_en, a_ram_addr, a_gnt, a_rd_valid, a_rd_data, a_rd_id, a_rd_last, a_done);
        mon_one(1, b_ram_en, b_ram_addr, b_gnt, b_rd_valid, b_rd_data, b_rd_id, b_rd_last, b_done);
    endtask

    task automatic reset_chk(input int u, input logic rclk, input logic rrst, input logic en,
                             input logic [3:0] we, input logic [31:0] wd, input logic [31:0] addr,
                             input logic [1:0] g, input logic vld, input logic [31:0] dat,
                             input logic id, input logic last, input logic [1:0] dn);
        chk("rst_ram_clk", u, 32'(rclk), 32'(clk));
        chk("rst_ram_rst", u, 32'(rrst), 32'd0);
        chk("rst_ram_en", u, 32'(en), 32'd0);
        chk("rst_ram_we", u, 32'(we), 32'd0);
        chk("rst_ram_wd", u, wd, 32'd0);
        chk("rst_ram_addr", u, addr, 32'd0);
        chk("rst_gnt", u, 32'(g), 32'd0);
        chk("rst_rd_valid", u, 32'(vld), 32'd0);
        chk("rst_rd_data", u, dat, 32'd0);
        chk("rst_rd_id", u, 32'(id), 32'd0);
        chk("rst_rd_last", u, 32'(last), 32'd0);
        chk("rst_done", u, 32'(dn), 32'd0);
    endtask

    task automatic push_burst(input int u, input int id, input logic [31:0] addr, input int len);
        exp_t e;
        for (int k = 0; k <= len; k++) begin
            e.u    = u[0];
            e.id   = id[0];
            e.addr = addr + 32'(k) * 32'd4;
            e.last = (k == len);
            iss_q.push_back(e);
            sb_q.push_back(e);
        end
    endtask

    task automatic set_fields(input int u, input int id, input logic [31:0] addr, input int len);
        if (id == 0) begin
            ra0[u] = addr;
            rl0[u] = 8'(len);
        end else begin
            ra1[u] = addr;
            rl1[u] = 8'(len);
        end
    endtask

    task automatic start(input int u, input int id, input logic [31:0] addr, input int len);
        set_fields(u, id, addr, len);
        push_burst(u, id, addr, len);
        req_s[u][id] = 1'b1;
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        while ((iss_q.size() != 0 || sb_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("burst_complete", 0, 32'(iss_q.size() + sb_q.size()), 32'd0);
        repeat (2) cycle();
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_s[u] = 2'b00;
            ra0[u] = '0; ra1[u] = '0; rl0[u] = '0; rl1[u] = '0;
            keep[u] = 2'b00;
            prev_last[u] = 1'b0;
            done_cnt[u][0] = 0;
            done_cnt[u][1] = 0;
        end
        repeat (2) @(negedge clk);
        reset_chk(0, a_ram_clk, a_ram_rst, a_ram_en, a_ram_we, a_ram_wd, a_ram_addr, a_gnt,
                  a_rd_valid, a_rd_data, a_rd_id, a_rd_last, a_done);
        reset_chk(1, b_ram_clk, b_ram_rst, b_ram_en, b_ram_we, b_ram_wd, b_ram_addr, b_gnt,
                  b_rd_valid, b_rd_data, b_rd_id, b_rd_last, b_done);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Simultaneous requests straight after reset: requester 0 first in both modes.
        set_fields(0, 0, 32'h0000_1000, 1);
        set_fields(0, 1, 32'h0000_2000, 2);
        push_burst(0, 0, 32'h0000_1000, 1);
        push_burst(0, 1, 32'h0000_2000, 2);
        req_s[0] = 2'b11;
        run_until_empty(60);

        // Single four-beat burst.
        start(0, 0, 32'h4580_0000, 3);
        run_until_empty(40);

        // Requester 0 held across two bursts while requester 1 waits.
        set_fields(0, 0, 32'h0000_3000, 1);
        set_fields(0, 1, 32'h0000_4000, 0);
`ifdef BRAM_RD_ARB_RR_EN
        push_burst(0, 1, 32'h0000_4000, 0);
        push_burst(0, 0, 32'h0000_3000, 1);
        push_burst(0, 0, 32'h0000_3000, 1);
`else
        push_burst(0, 0, 32'h0000_3000, 1);
        push_burst(0, 0, 32'h0000_3000, 1);
        push_burst(0, 1, 32'h0000_4000, 0);
`endif
        keep[0] = 2'b01;
        req_s[0] = 2'b11;
        n = done_cnt[0][0];
        for (int i = 0; i < 60 && done_cnt[0][0] == n; i++) cycle();
        keep[0] = 2'b00;
        run_until_empty(80);

        // Top-of-memory single beat, a wrapping burst, then a burst from zero.
        start(0, 0, 32'hFFFF_FFFC, 0);
        run_until_empty(20);
        start(0, 1, 32'hFFFF_FFFC, 1);
        run_until_empty(20);
        start(0, 0, 32'h0000_0000, 2);
        run_until_empty(20);

        // Three-cycle BRAM latency instance.
        start(1, 0, 32'h0000_0100, 1);
        run_until_empty(30);
        start(1, 1, 32'h0000_0200, 3);
        run_until_empty(30);

        // Reset while beat 2 of an eight-beat burst is on the bus.
        start(0, 1, 32'h0000_8000, 7);
        for (int i = 0; i < 20 && iss_q.size() > 5; i++) cycle();
        chk("reset_at_beat2", 0, 32'(iss_q.size()), 32'd5);
        rst_n = 1'b0;
        #1;
        reset_chk(0, a_ram_clk, a_ram_rst, a_ram_en, a_ram_we, a_ram_wd, a_ram_addr, a_gnt,
                  a_rd_valid, a_rd_data, a_rd_id, a_rd_last, a_done);
        iss_q.delete();
        sb_q.delete();
        tq.delete();
        req_s[0] = 2'b00;
        prev_last[0] = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (12) cycle();
        start(0, 0, 32'h0000_9000, 2);
        run_until_empty(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_rd_arbiter.md
BRAM_RD_ARBITER -- requirements
Module: bram_rd_arbiter

Interface
REQ-001 SHALL have parameter RD_LATENCY, default 1: cycles from an address on ram_addr with ram_en=1 to valid ram_rd_data; legal range 1..4.
REQ-002 SHALL have parameter ADDR_STEP, default 4: byte increment of ram_addr per beat.
REQ-003 SHALL have parameter LEN_W, default 8: width of the burst-length fields.
REQ-004 SHALL have port clk  in  1: single clock for all logic.
REQ-005 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port ram_clk  out  1: driven directly by clk.
REQ-007 SHALL have port ram_rst  out  1: constant 0.
REQ-008 SHALL have port ram_en  out  1: high only while a beat address is issued.
REQ-009 SHALL have port ram_we  out  4: constant 0 (read-only port).
REQ-010 SHALL have port ram_wd_data  out  32: constant 0.
REQ-011 SHALL have port ram_addr  out  32: registered beat address.
REQ-012 SHALL have port ram_rd_data  in  32: BRAM read data.
REQ-013 SHALL have port req  in  2: per-requester level request, held until its done pulse.
REQ-014 SHALL have port req_addr0 / req_addr1  in  32 each: burst start byte address.
REQ-015 SHALL have port req_len0 / req_len1  in  LEN_W each: beat count minus one.
REQ-016 SHALL have port gnt  out  2: one-hot grant, held for the whole burst including drain.
REQ-017 SHALL have port rd_data  out  32: registered copy of ram_rd_data.
REQ-018 SHALL have port rd_valid  out  1: rd_data qualifier.
REQ-019 SHALL have port rd_id  out  1: requester owning rd_data.
REQ-020 SHALL have port rd_last  out  1: final beat of a burst.
REQ-021 SHALL have port done  out  2: one-cycle pulse per requester, coincident with its rd_last beat.

Function
REQ-022 SHALL use FSM states IDLE, ISSUE and DRAIN.
REQ-023 In IDLE with any req bit set, SHALL select a winner and latch its addr/len, set gnt, and move to ISSUE on the next cycle.
REQ-024 In ISSUE, SHALL drive ram_en=1 and ram_addr=start+k*ADDR_STEP for beat k=0..len, one beat per cycle, with no stalls.
REQ-025 After issuing beat len, SHALL enter DRAIN with ram_en=0 and ram_addr=0.
REQ-026 SHALL assert rd_valid, carrying rd_id and rd_last, exactly RD_LATENCY+1 cycles after the corresponding beat address; valid/id/last SHALL travel in a shift pipeline alongside the data.
REQ-027 SHALL leave DRAIN for IDLE in the cycle after the rd_last beat, clearing gnt in that same transition.
REQ-028 A new arbitration SHALL occur only in IDLE, so bursts never overlap; minimum gap between bursts is one IDLE cycle.
REQ-029 req_len=0 SHALL produce a single-beat burst with rd_last on that beat.
REQ-030 Address arithmetic SHALL wrap modulo 2^32 without a flag.
REQ-031 Deassertion of req mid-burst SHALL be ignored; the burst SHALL complete.
REQ-032 ram_addr SHALL be 0 whenever ram_en=0.

Reset
REQ-033 rst_n low SHALL immediately force FSM=IDLE, gnt=0, ram_en=0, ram_addr=0, rd_valid=0, rd_last=0, rd_id=0, done=0, rd_data=0, clear the pipeline, and set the round-robin pointer to favour requester 0.
REQ-034 Reset mid-burst SHALL abandon the burst: no further done or rd_valid for it.

Configuration
REQ-035 With BRAM_RD_ARB_RR_EN defined, SHALL arbitrate round-robin: on simultaneous requests the non-last-granted requester wins, and the pointer updates at each grant.
REQ-036 Without BRAM_RD_ARB_RR_EN, SHALL use fixed priority, requester 0 over requester 1, with no pointer register.

Structure
REQ-037 A shared package SHALL hold the FSM state typedef (IDLE/ISSUE/DRAIN), the requester-count constant 2 and the RD_LATENCY maximum of 4.
REQ-038 The valid/id/last delay line SHALL be a sub-module named bram_rd_lat_pipe, parameterised by depth.

Verification
REQ-039 Single request: req0, addr 0x4580_0000, len 3, RD_LATENCY=1 -> ram_addr 0x4580_0000/04/08/0C on consecutive cycles; four rd_valid beats from 2 cycles after the first address; rd_last and done[0] on the fourth.
REQ-040 Simultaneous req=2'b11 with RR_EN -> gnt 01 first, then 10; with RR_EN off and req0 held -> requester 0 granted back-to-back and requester 1 starved.
REQ-041 len=0 at addr 0xFFFF_FFFC -> one beat, rd_last=1, done pulse; next burst from 0x0000_0000 issues normally.
REQ-042 RD_LATENCY=3, len 1 -> rd_valid exactly 4 cycles after each address; gnt held until rd_last.
REQ-043 rst_n low during beat 2 of a len-7 burst -> all outputs at reset values within the same cycle; no done after release; a fresh request is served correctly.
